// File: rtl/axis_uart_tx_pkg.sv
// axis_uart_tx_pkg: UART framing states and board-clock default, shared by the UART TX and RX blocks.
package axis_uart_tx_pkg;
  localparam int DEFAULT_CLOCK_DIV = 104;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
endpackage

// File: rtl/uart_baud_div.sv
// uart_baud_div: bit-period down-counter; tick marks the last cycle of each bit, load restarts a full bit.
module uart_baud_div #(
  parameter int CLOCK_DIV = 104
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  output logic tick
);
  localparam int W = $clog2(CLOCK_DIV);
  localparam logic [W-1:0] RELOAD = W'(CLOCK_DIV - 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_cnt <= '0;
    else r_cnt <= (load || r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
  end
  assign tick = !load && r_cnt == '0;
endmodule

// File: rtl/axis_uart_tx.sv
// axis_uart_tx: AXI-stream sink that serialises each word as start, data LSB first, [parity], stop bit(s).
// Define AXIS_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module axis_uart_tx
  import axis_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLOCK_DIV  = DEFAULT_CLOCK_DIV,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  ivalid,
  output logic                  iready,
  output logic                  txd,
  output logic                  busy
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit;
  logic                  r_txd;
  logic                  w_load;
  logic                  w_tick;
`ifdef AXIS_UART_TX_PARITY_EN
  logic                  r_par;
`endif
  assign iready = r_state == ST_IDLE;
  assign busy   = !iready;
  assign txd    = r_txd;
  assign w_load = ivalid && iready;
  uart_baud_div #(.CLOCK_DIV(CLOCK_DIV)) u_baud (
    .clock  (clock),
    .resetn (resetn),
    .load   (w_load),
    .tick   (w_tick)
  );
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_txd   <= 1'b1;
`ifdef AXIS_UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (w_load) begin
          r_shift <= idata;
          r_txd   <= 1'b0;
          r_state <= ST_START;
`ifdef AXIS_UART_TX_PARITY_EN
          r_par   <= ^idata;
`endif
        end
        ST_START: if (w_tick) begin
          r_state <= ST_DATA;
          r_txd   <= r_shift[0];
          r_shift <= r_shift >> 1;
          r_bit   <= '0;
        end
        ST_DATA: if (w_tick) begin
          if (r_bit == LAST_BIT) begin
            r_bit <= '0;
`ifdef AXIS_UART_TX_PARITY_EN
            r_state <= ST_PARITY;
            r_txd   <= r_par;
`else
            r_state <= ST_STOP;
            r_txd   <= 1'b1;
`endif
          end else begin
            r_txd   <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 1'b1;
          end
        end
        ST_PARITY: if (w_tick) begin
          r_state <= ST_STOP;
          r_txd   <= 1'b1;
          r_bit   <= '0;
        end
        ST_STOP: if (w_tick) begin
          r_state <= (r_bit == LAST_STOP) ? ST_IDLE : ST_STOP;
          r_bit   <= (r_bit == LAST_STOP) ? '0 : r_bit + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`ifdef FORMAL
`ifdef AXIS_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (1 + DATA_WIDTH + P + STOP_BITS) * CLOCK_DIV;
  logic [31:0] r_len;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_len <= '0;
    else begin
      r_len <= busy ? r_len + 1 : '0;
      if (iready) assert (r_txd);
      assert (iready == !busy);
      if (iready && r_len != 0) assert (r_len == FRAME);
    end
  end
`endif
endmodule

// File: tb/tb_axis_uart_tx.sv
// tb_axis_uart_tx: directed and random frames compared cycle by cycle against a bit-slot model of the UART line.
module tb_axis_uart_tx;
  localparam int CD = 4;
  localparam int SB = 1;
`ifdef AXIS_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = (1 + 8 + P + SB) * CD;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ivalid = 1'b0;
  logic [7:0] idata = 8'h00;
  logic       iready, txd, busy;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  axis_uart_tx #(.DATA_WIDTH(8), .CLOCK_DIV(CD), .STOP_BITS(SB)) dut (
    .clock  (clk),
    .resetn (rst_n),
    .idata  (idata),
    .ivalid (ivalid),
    .iready (iready),
    .txd    (txd),
    .busy   (busy)
  );
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  function automatic logic exp_bit(input logic [7:0] d, input int c);
    int slot;
    slot = c / CD;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (P == 1 && slot == 9) return ^d;
    return 1'b1;
  endfunction
  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    while (!iready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", iready, 1'b1);
    idata = d;
    ivalid = 1'b1;
    @(posedge clk);
  endtask
  task automatic frame(input logic [7:0] d, input bit hold, input logic [7:0] nd, input bit glitch);
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (hold) idata = nd;
        else ivalid = 1'b0;
      end
      if (glitch && c == 10) begin
        ivalid = 1'b1;
        idata = ~d;
      end
      if (glitch && c == 14) ivalid = 1'b0;
      chk("frame_txd", txd, exp_bit(d, c));
      chk("frame_iready", iready, 1'b0);
      chk("frame_busy", busy, 1'b1);
    end
    @(negedge clk);
    chk("gap_txd", txd, 1'b1);
    chk("gap_iready", iready, 1'b1);
    chk("gap_busy", busy, 1'b0);
  endtask
  initial begin
    logic [7:0] d;
    repeat (2) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_iready", iready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_txd", txd, 1'b1);
      chk("idle_iready", iready, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end
    send(8'hA5);
    frame(8'hA5, 1'b0, 8'h00, 1'b0);
    send(8'h00);
    frame(8'h00, 1'b1, 8'hFF, 1'b0);
    send(8'hFF);
    frame(8'hFF, 1'b0, 8'h00, 1'b0);
    send(8'hC3);
    frame(8'hC3, 1'b0, 8'h00, 1'b1);
    send(8'h07);
    frame(8'h07, 1'b0, 8'h00, 1'b0);
    send(8'h52);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) ivalid = 1'b0;
      chk("pre_reset_txd", txd, exp_bit(8'h52, c));
    end
    rst_n = 1'b0;
    #1;
    chk("async_rst_txd", txd, 1'b1);
    chk("async_rst_iready", iready, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h3C);
    frame(8'h3C, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rand_idle_txd", txd, 1'b1);
      end
      send(d);
      frame(d, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
